// File: rtl/usb_txn_sequencer.sv
// Host-side USB transaction sequencer: token/data send, receive window, handshake classification, retries, one response per request.
// Latency follows the encoder/decoder handshakes and the device reply; accepts a request only when idle and stalls sends on encoder_ready.
module usb_txn_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_in,
    input  logic [98:0]      req_tok,
    input  logic [98:0]      req_data,
    output logic             rsp_valid,
    output logic [1:0]       rsp_status,
    output logic [98:0]      rsp_pkt,
    output logic [CNT_W-1:0] rsp_attempts,
    output logic [98:0]      pkt_in,
    output logic             pkt_in_avail,
    input  logic             encoder_ready,
    input  logic [98:0]      pkt_out,
    input  logic             pkt_out_avail,
    input  logic             data_good,
    input  logic             decoder_ready,
    output logic             re
);

    localparam logic [7:0]  PID_ACK   = 8'hD2;
    localparam logic [7:0]  PID_NAK   = 8'h5A;
    localparam logic [7:0]  PID_DATA0 = 8'hC3;
    localparam logic [7:0]  PID_DATA1 = 8'h4B;
    localparam logic [98:0] ACK_PKT   = {PID_ACK, 91'b0};

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_TOK,
        S_SEND_DATA,
        S_SEND_ACK,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RX_ARM,
        S_RX_WAIT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        K_TOK,
        K_DATA,
        K_ACK
    } kind_t;

    state_t           r_state;
    state_t           w_state_nx;
    kind_t            r_kind;
    kind_t            w_send_kind;

    logic             r_is_in;
    logic [98:0]      r_tok;
    logic [98:0]      r_data;
    logic [98:0]      r_pkt_in;
    logic             r_pkt_in_avail;
    logic             r_re;
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_attempts;
    logic [98:0]      r_rsp_pkt;
    logic [1:0]       r_status;
    logic             r_rsp_vld;

    logic             w_accept;
    logic             w_send;
    logic [98:0]      w_send_pkt;
    logic             w_arm;
    logic             w_capture;
    logic             w_fail;
    logic             w_fail_nak;
    logic             w_retry;
    logic             w_finish;
    logic [1:0]       w_fin_status;
    logic [7:0]       w_pid;
    logic [CNT_W-1:0] w_tmo_inc;
    logic             w_tmo_hit;

    assign w_pid     = pkt_out[98:91];
    assign w_tmo_inc = r_tmo + CNT_W'(1);
    // A packet arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo_hit = (w_tmo_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_accept     = 1'b0;
        w_send       = 1'b0;
        w_send_pkt   = '0;
        w_send_kind  = r_kind;
        w_arm        = 1'b0;
        w_capture    = 1'b0;
        w_fail       = 1'b0;
        w_fail_nak   = 1'b0;
        w_retry      = 1'b0;
        w_finish     = 1'b0;
        w_fin_status = ST_OK;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_SEND_TOK;
                end
            end
            S_SEND_TOK: begin
                if (encoder_ready) begin
                    w_send      = 1'b1;
                    w_send_pkt  = r_tok;
                    w_send_kind = K_TOK;
                    w_state_nx  = S_WAIT_LO;
                end
            end
            S_SEND_DATA: begin
                if (encoder_ready) begin
                    w_send      = 1'b1;
                    w_send_pkt  = r_data;
                    w_send_kind = K_DATA;
                    w_state_nx  = S_WAIT_LO;
                end
            end
            S_SEND_ACK: begin
                if (encoder_ready) begin
                    w_send      = 1'b1;
                    w_send_pkt  = ACK_PKT;
                    w_send_kind = K_ACK;
                    w_state_nx  = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!encoder_ready) begin
                    w_state_nx = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (encoder_ready) begin
                    case (r_kind)
                        K_TOK:   w_state_nx = r_is_in ? S_RX_ARM : S_SEND_DATA;
                        K_DATA:  w_state_nx = S_RX_ARM;
                        K_ACK: begin
                            w_state_nx = S_FINISH;
                            w_finish   = 1'b1;
                        end
                        default: w_state_nx = S_IDLE;
                    endcase
                end
            end
            S_RX_ARM: begin
                if (decoder_ready) begin
                    w_arm      = 1'b1;
                    w_state_nx = S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                if (pkt_out_avail) begin
                    if (!data_good) begin
                        w_fail = 1'b1;
                    end else if (!r_is_in) begin
                        if (w_pid == PID_ACK) begin
                            w_state_nx = S_FINISH;
                            w_finish   = 1'b1;
                        end else begin
                            w_fail     = 1'b1;
                            w_fail_nak = (w_pid == PID_NAK);
                        end
                    end else begin
                        if (w_pid == PID_DATA0 || w_pid == PID_DATA1) begin
                            w_capture  = 1'b1;
                            w_state_nx = S_SEND_ACK;
                        end else begin
                            w_fail     = 1'b1;
                            w_fail_nak = (w_pid == PID_NAK);
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_fail = 1'b1;
                end

                // The status on exhaustion reflects only the final failed attempt.
                if (w_fail) begin
                    if (r_attempts < CNT_W'(MAX_RETRY)) begin
                        w_retry    = 1'b1;
                        w_state_nx = S_SEND_TOK;
                    end else begin
                        w_finish     = 1'b1;
                        w_fin_status = w_fail_nak ? ST_NAK : ST_ERR;
                        w_state_nx   = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_is_in        <= 1'b0;
            r_tok          <= '0;
            r_data         <= '0;
            r_kind         <= K_TOK;
            r_pkt_in       <= '0;
            r_pkt_in_avail <= 1'b0;
            r_re           <= 1'b0;
            r_tmo          <= '0;
            r_attempts     <= '0;
            r_rsp_pkt      <= '0;
            r_status       <= ST_OK;
            r_rsp_vld      <= 1'b0;
        end else begin
            r_pkt_in_avail <= w_send;
            r_re           <= (w_state_nx == S_RX_WAIT);
            r_rsp_vld      <= (w_state_nx == S_FINISH);

            if (w_accept) begin
                r_is_in    <= req_is_in;
                r_tok      <= req_tok;
                r_data     <= req_data;
                r_attempts <= CNT_W'(1);
                r_rsp_pkt  <= '0;
                r_status   <= ST_OK;
            end

            if (w_send) begin
                r_pkt_in <= w_send_pkt;
                r_kind   <= w_send_kind;
            end

            if (w_arm) begin
                r_tmo <= '0;
            end else if (r_state == S_RX_WAIT) begin
                r_tmo <= w_tmo_inc;
            end

            if (w_retry) begin
                r_attempts <= r_attempts + CNT_W'(1);
                r_rsp_pkt  <= '0;
            end

            if (w_capture) begin
                r_rsp_pkt <= pkt_out;
            end

            if (w_finish) begin
                r_status <= w_fin_status;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign rsp_valid    = r_rsp_vld;
    assign rsp_status   = r_status;
    assign rsp_pkt      = r_rsp_pkt;
    assign rsp_attempts = r_attempts;
    assign pkt_in       = r_pkt_in;
    assign pkt_in_avail = r_pkt_in_avail;
    assign re           = r_re;

    // Transmit and receive windows are mutually exclusive on the shared line.
    a_no_tx_during_rx: assert property (@(posedge clk) disable iff (!rst_b) !(r_pkt_in_avail && r_re));

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Scoreboard bench for usb_txn_sequencer with an encoder handshake model and a scripted device reply model.
module tb_usb_txn_sequencer;

    localparam int TMO   = 10;
    localparam int MAXR  = 3;
    localparam int CW    = 8;
    localparam int BOUND = 2000;

    typedef struct {
        bit          reply;
        logic [98:0] pkt;
        bit          good;
        int          at;
    } reply_t;

    typedef struct {
        logic [1:0]    st;
        logic [98:0]   pkt;
        logic [CW-1:0] att;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_in;
    logic [98:0]   req_tok;
    logic [98:0]   req_data;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [98:0]   rsp_pkt;
    logic [CW-1:0] rsp_attempts;
    logic [98:0]   pkt_in;
    logic          pkt_in_avail;
    logic          encoder_ready;
    logic [98:0]   pkt_out;
    logic          pkt_out_avail;
    logic          data_good;
    logic          decoder_ready;
    logic          re;

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    reply_t      dev_q[$];
    rsp_t        exp_rsp[$];
    logic [98:0] exp_pkts[$];
    logic [98:0] obs_pkts[$];
    int          re_lens[$];

    always #5 clk = ~clk;

    usb_txn_sequencer #(.TIMEOUT(TMO), .MAX_RETRY(MAXR), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_in(req_is_in),
        .req_tok(req_tok), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_pkt(rsp_pkt), .rsp_attempts(rsp_attempts),
        .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail), .encoder_ready(encoder_ready),
        .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail), .data_good(data_good),
        .decoder_ready(decoder_ready), .re(re)
    );

    // Encoder drops ready for two cycles per packet; the device answers at a scripted re-window cycle.
    initial begin : models
        int     re_cnt;
        int     enc_lo;
        bit     have;
        reply_t cur;
        re_cnt = 0; enc_lo = 0; have = 1'b0;
        encoder_ready = 1'b1; pkt_out = '0; pkt_out_avail = 1'b0; data_good = 1'b0;
        forever begin
            @(negedge clk);
            if (pkt_in_avail) obs_pkts.push_back(pkt_in);
            if (pkt_in_avail && re) viol++;
            if (pkt_in_avail) begin
                encoder_ready = 1'b0;
                enc_lo = 2;
            end else if (enc_lo > 0) begin
                enc_lo--;
                if (enc_lo == 0) encoder_ready = 1'b1;
            end
            if (re) re_cnt++;
            else begin
                if (re_cnt > 0) re_lens.push_back(re_cnt);
                re_cnt = 0;
            end
            pkt_out_avail = 1'b0;
            data_good = 1'b0;
            if (re && re_cnt == 1) begin
                have = (dev_q.size() > 0);
                if (have) cur = dev_q.pop_front();
            end
            if (re && have && cur.reply && re_cnt == cur.at) begin
                pkt_out = cur.pkt;
                data_good = cur.good;
                pkt_out_avail = 1'b1;
            end
        end
    end

    function automatic logic [98:0] mk(input logic [7:0] pid);
        return {pid, 27'd0, $urandom(), $urandom()};
    endfunction

    task automatic clear_sb();
        dev_q.delete(); exp_rsp.delete(); exp_pkts.delete(); obs_pkts.delete(); re_lens.delete();
    endtask

    task automatic run(input bit is_in, input logic [98:0] tok, input logic [98:0] dat, output bit got);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_is_in = is_in; req_tok = tok; req_data = dat;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < BOUND) begin
            if (rsp_valid) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
    endtask

    task automatic check_txn(input string nm, input bit got);
        rsp_t e;
        logic [98:0] ep, op;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s rsp_valid: not seen within %0d cycles", nm, BOUND);
        end else begin
            e = exp_rsp.pop_front();
            n_cmp++;
            if (rsp_status !== e.st) begin n_bad++; $display("FAIL %s status: got %b want %b", nm, rsp_status, e.st); end
            n_cmp++;
            if (rsp_attempts !== e.att) begin n_bad++; $display("FAIL %s attempts: got %0d want %0d", nm, rsp_attempts, e.att); end
            n_cmp++;
            if (rsp_pkt !== e.pkt) begin n_bad++; $display("FAIL %s rsp_pkt: got %h want %h", nm, rsp_pkt, e.pkt); end
        end
        n_cmp++;
        if (obs_pkts.size() != exp_pkts.size()) begin
            n_bad++;
            $display("FAIL %s sent count: got %0d want %0d", nm, obs_pkts.size(), exp_pkts.size());
        end
        while (exp_pkts.size() > 0 && obs_pkts.size() > 0) begin
            ep = exp_pkts.pop_front();
            op = obs_pkts.pop_front();
            n_cmp++;
            if (op !== ep) begin n_bad++; $display("FAIL %s sent pkt: got %h want %h", nm, op, ep); end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)   begin n_bad++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_status !== 2'b00) begin n_bad++; $display("FAIL reset rsp_status: got %b want 00", rsp_status); end
        n_cmp++; if (rsp_pkt !== 99'b0)    begin n_bad++; $display("FAIL reset rsp_pkt: got %h want 0", rsp_pkt); end
        n_cmp++; if (rsp_attempts !== '0)  begin n_bad++; $display("FAIL reset rsp_attempts: got %0d want 0", rsp_attempts); end
        n_cmp++; if (pkt_in !== 99'b0)     begin n_bad++; $display("FAIL reset pkt_in: got %h want 0", pkt_in); end
        n_cmp++; if (pkt_in_avail !== 1'b0) begin n_bad++; $display("FAIL reset pkt_in_avail: got %b want 0", pkt_in_avail); end
        n_cmp++; if (re !== 1'b0)          begin n_bad++; $display("FAIL reset re: got %b want 0", re); end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_out_ack();
        logic [98:0] tok, dat;
        bit got;
        clear_sb();
        tok = mk(8'hE1); dat = mk(8'hC3);
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b1, 2});
        exp_pkts.push_back(tok); exp_pkts.push_back(dat);
        exp_rsp.push_back('{2'b00, 99'b0, 8'd1});
        run(1'b0, tok, dat, got);
        check_txn("out_ack", got);
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL out_ack pulse width: rsp_valid=%b want 0", rsp_valid); end
        n_cmp++; if (rsp_attempts !== 8'd1) begin n_bad++; $display("FAIL out_ack hold: attempts=%0d want 1", rsp_attempts); end
        n_cmp++; if (re_lens.size() != 1) begin n_bad++; $display("FAIL out_ack windows: got %0d want 1", re_lens.size()); end
    endtask

    task automatic test_out_nak_retry();
        logic [98:0] tok, dat;
        bit got;
        clear_sb();
        tok = mk(8'h87); dat = mk(8'h4B);
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 3});
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 1});
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b1, 4});
        for (int i = 0; i < 3; i++) begin exp_pkts.push_back(tok); exp_pkts.push_back(dat); end
        exp_rsp.push_back('{2'b00, 99'b0, 8'd3});
        run(1'b0, tok, dat, got);
        check_txn("out_nak_retry", got);
    endtask

    task automatic test_in_data();
        logic [98:0] tok, dat, rx;
        bit got;
        clear_sb();
        tok = mk(8'h69); dat = mk(8'hC3);
        rx = {8'h4B, 91'h1234_5678_9abc_def0_1357};
        dev_q.push_back('{1'b1, rx, 1'b1, 2});
        exp_pkts.push_back(tok); exp_pkts.push_back({8'hD2, 91'b0});
        exp_rsp.push_back('{2'b00, rx, 8'd1});
        run(1'b1, tok, dat, got);
        check_txn("in_data", got);
    endtask

    task automatic test_in_nak_then_data0();
        logic [98:0] tok, rx;
        bit got;
        clear_sb();
        tok = mk(8'h69);
        rx = mk(8'hC3);
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 2});
        dev_q.push_back('{1'b1, rx, 1'b1, 5});
        exp_pkts.push_back(tok); exp_pkts.push_back(tok); exp_pkts.push_back({8'hD2, 91'b0});
        exp_rsp.push_back('{2'b00, rx, 8'd2});
        run(1'b1, tok, mk(8'hC3), got);
        check_txn("in_nak_data0", got);
    endtask

    task automatic test_in_err_timeout();
        logic [98:0] tok;
        bit got;
        clear_sb();
        tok = mk(8'h69);
        dev_q.push_back('{1'b1, mk(8'hC3), 1'b0, 2});
        dev_q.push_back('{1'b1, mk(8'h4B), 1'b0, 3});
        dev_q.push_back('{1'b0, 99'b0, 1'b0, 0});
        for (int i = 0; i < 3; i++) exp_pkts.push_back(tok);
        exp_rsp.push_back('{2'b10, 99'b0, 8'd3});
        run(1'b1, tok, mk(8'hC3), got);
        check_txn("in_err_timeout", got);
        @(negedge clk);
        n_cmp++;
        if (re_lens.size() != 3 || re_lens[2] != TMO) begin
            n_bad++;
            $display("FAIL in_err_timeout windows: got %0d windows, last %0d, want 3 with last %0d",
                     re_lens.size(), (re_lens.size() > 0) ? re_lens[re_lens.size()-1] : -1, TMO);
        end
    endtask

    task automatic test_retry_limits();
        logic [98:0] tok, dat;
        bit got;
        clear_sb();
        tok = mk(8'hE1); dat = mk(8'hC3);
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 2});
        dev_q.push_back('{1'b1, mk(8'hC3), 1'b1, 2});
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 2});
        for (int i = 0; i < 3; i++) begin exp_pkts.push_back(tok); exp_pkts.push_back(dat); end
        exp_rsp.push_back('{2'b01, 99'b0, 8'd3});
        run(1'b0, tok, dat, got);
        check_txn("nak_limit", got);

        clear_sb();
        tok = mk(8'hE1); dat = mk(8'h4B);
        dev_q.push_back('{1'b1, {8'h5A, 91'b0}, 1'b1, 2});
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b0, 2});
        dev_q.push_back('{1'b0, 99'b0, 1'b0, 0});
        for (int i = 0; i < 3; i++) begin exp_pkts.push_back(tok); exp_pkts.push_back(dat); end
        exp_rsp.push_back('{2'b10, 99'b0, 8'd3});
        run(1'b0, tok, dat, got);
        check_txn("err_limit", got);
    endtask

    task automatic test_timeout_boundary();
        logic [98:0] tok, dat;
        bit got;
        clear_sb();
        tok = mk(8'hE1); dat = mk(8'hC3);
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b1, TMO});
        exp_pkts.push_back(tok); exp_pkts.push_back(dat);
        exp_rsp.push_back('{2'b00, 99'b0, 8'd1});
        run(1'b0, tok, dat, got);
        check_txn("tmo_edge_pkt", got);
        @(negedge clk);
        n_cmp++;
        if (re_lens.size() != 1 || re_lens[0] != TMO) begin
            n_bad++; $display("FAIL tmo_edge_pkt window: got %0d windows, want 1 of %0d", re_lens.size(), TMO);
        end

        clear_sb();
        dev_q.push_back('{1'b0, 99'b0, 1'b0, 0});
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b1, 2});
        for (int i = 0; i < 2; i++) begin exp_pkts.push_back(tok); exp_pkts.push_back(dat); end
        exp_rsp.push_back('{2'b00, 99'b0, 8'd2});
        run(1'b0, tok, dat, got);
        check_txn("tmo_retry", got);
        @(negedge clk);
        n_cmp++;
        if (re_lens.size() != 2 || re_lens[0] != TMO || re_lens[1] != 2) begin
            n_bad++; $display("FAIL tmo_retry windows: got %0d windows, want lengths %0d then 2", re_lens.size(), TMO);
        end
    endtask

    task automatic test_reset_mid_rx();
        logic [98:0] tok, dat;
        bit got;
        int n;
        clear_sb();
        tok = mk(8'hE1); dat = mk(8'hC3);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_is_in = 1'b0; req_tok = tok; req_data = dat;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!re && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL rst_mid re window: got re=%b want 1", re); end
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        n_cmp++; if (re !== 1'b0)           begin n_bad++; $display("FAIL rst_mid re: got %b want 0", re); end
        n_cmp++; if (pkt_in_avail !== 1'b0) begin n_bad++; $display("FAIL rst_mid pkt_in_avail: got %b want 0", pkt_in_avail); end
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_mid rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1)    begin n_bad++; $display("FAIL rst_mid req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        clear_sb();
        tok = mk(8'hE1); dat = mk(8'h4B);
        dev_q.push_back('{1'b1, {8'hD2, 91'b0}, 1'b1, 3});
        exp_pkts.push_back(tok); exp_pkts.push_back(dat);
        exp_rsp.push_back('{2'b00, 99'b0, 8'd1});
        run(1'b0, tok, dat, got);
        check_txn("after_rst", got);
    endtask

    initial begin
        rst_b = 1'b0;
        req_valid = 1'b0; req_is_in = 1'b0; req_tok = '0; req_data = '0;
        decoder_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_out_ack();
        test_out_nak_retry();
        test_in_data();
        test_in_nak_then_data0();
        test_in_err_timeout();
        test_retry_limits();
        test_timeout_boundary();
        test_reset_mid_rx();
        n_cmp++;
        if (viol != 0) begin n_bad++; $display("FAIL tx_during_rx: got %0d overlaps want 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
